oam_eval_seq: RTL and testbench

Sequencer for PPU sprite evaluation. It scans the 64 primary OAM entries for the current scanline and copies up to 8 in-range sprites into the 32-byte secondary OAM, clearing that buffer beforehand. It also raises the sprite-overflow flag and the sprite-0 marker consumed by the OAM evaluation datapath and the sprite FIFO. It sits between the H/V decoder (phase strobes, scanline) and the primary/secondary OAM arrays.

---
 rtl/oam_eval_seq.sv | 190 +++++++++++++++++++
 tb/tb_oam_eval_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_eval_seq.sv
// Sprite evaluation sequencer: clears secondary OAM, scans 64 primary OAM entries, copies up to 8 in-range sprites.
// Optional OAM_EVAL_OVF_BUG_EN reproduces the diagonal (n++, m++) overflow scan of the original hardware.
module oam_eval_seq (
    input  logic       PCLK,
    input  logic       RES,
    input  logic       CLR_START,
    input  logic       EVAL_START,
    input  logic       EVAL,
    input  logic       CLR_OV,
    input  logic [7:0] V_LINE,
    input  logic       OBJ_H16,
    input  logic [7:0] OAM_DI,
    output logic [7:0] OAM_A,
    output logic [4:0] OAM2_A,
    output logic [7:0] OAM2_DO,
    output logic       OAM2_WE,
    output logic [3:0] SPR_CNT,
    output logic       SPR_OV,
    output logic       SPR0_EV,
    output logic       DONE
);

    typedef enum logic [3:0] {
        IDLE, CLEAR, Y_RD, Y_CMP, CP_RD, CP_WR, OV_RD, OV_CMP, FIN
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] n, n_nxt;
    logic [1:0] m, m_nxt;
    logic [4:0] clr_idx, clr_idx_nxt;
    logic [3:0] spr_cnt, spr_cnt_nxt, cnt_inc;
    logic       spr_ov, spr_ov_nxt;
    logic       spr0_ev, spr0_ev_nxt;
    logic       done, done_nxt;

    logic [8:0] diff;
    logic       in_range;
    logic       in_eval;

    // Borrow out of the 9-bit subtract means the sprite starts below this line.
    assign diff     = {1'b0, V_LINE} - {1'b0, OAM_DI};
    assign in_range = !diff[8] && (diff[7:0] < (OBJ_H16 ? 8'd16 : 8'd8));
    assign in_eval  = (state == Y_RD) || (state == Y_CMP) || (state == CP_RD) ||
                      (state == CP_WR) || (state == OV_RD) || (state == OV_CMP);
    assign cnt_inc  = spr_cnt + 4'd1;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (RES) begin
            state   <= IDLE;
            n       <= '0;
            m       <= '0;
            clr_idx <= '0;
            spr_cnt <= '0;
            spr_ov  <= 1'b0;
            spr0_ev <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            n       <= n_nxt;
            m       <= m_nxt;
            clr_idx <= clr_idx_nxt;
            spr_cnt <= spr_cnt_nxt;
            spr_ov  <= spr_ov_nxt;
            spr0_ev <= spr0_ev_nxt;
            done    <= done_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        n_nxt       = n;
        m_nxt       = m;
        clr_idx_nxt = clr_idx;
        spr_cnt_nxt = spr_cnt;
        spr_ov_nxt  = spr_ov;
        spr0_ev_nxt = spr0_ev;
        done_nxt    = done;
        OAM_A       = 8'h00;
        OAM2_A      = 5'd0;
        OAM2_DO     = 8'h00;
        OAM2_WE     = 1'b0;

        unique case (state)
            IDLE: ;
            CLEAR: begin
                OAM2_WE     = 1'b1;
                OAM2_DO     = 8'hFF;
                OAM2_A      = clr_idx;
                clr_idx_nxt = clr_idx + 5'd1;
                if (clr_idx == 5'd31) state_nxt = IDLE;
            end
            Y_RD: begin
                OAM_A     = {n, 2'b00};
                state_nxt = Y_CMP;
            end
            Y_CMP: begin
                // The Y byte lands in the next free slot whether or not the sprite hits.
                OAM2_WE = 1'b1;
                OAM2_A  = {spr_cnt[2:0], 2'b00};
                OAM2_DO = OAM_DI;
                if (in_range) begin
                    m_nxt     = 2'd1;
                    state_nxt = CP_RD;
                    if (n == 6'd0) spr0_ev_nxt = 1'b1;
                end else if (n == 6'd63) begin
                    state_nxt = FIN;
                end else begin
                    n_nxt     = n + 6'd1;
                    state_nxt = Y_RD;
                end
            end
            CP_RD: begin
                OAM_A     = {n, m};
                state_nxt = CP_WR;
            end
            CP_WR: begin
                OAM2_WE = 1'b1;
                OAM2_A  = {spr_cnt[2:0], m};
                OAM2_DO = OAM_DI;
                if (m != 2'd3) begin
                    m_nxt     = m + 2'd1;
                    state_nxt = CP_RD;
                end else begin
                    spr_cnt_nxt = cnt_inc;
                    m_nxt       = 2'd0;
                    if (n == 6'd63) begin
                        state_nxt = FIN;
                    end else begin
                        n_nxt     = n + 6'd1;
                        state_nxt = (cnt_inc == 4'd8) ? OV_RD : Y_RD;
                    end
                end
            end
            OV_RD: begin
                OAM_A     = {n, m};
                state_nxt = OV_CMP;
            end
            OV_CMP: begin
                if (in_range) begin
                    spr_ov_nxt = 1'b1;
                    state_nxt  = FIN;
                end else if (n == 6'd63) begin
                    state_nxt = FIN;
                end else begin
                    n_nxt     = n + 6'd1;
`ifdef OAM_EVAL_OVF_BUG_EN
                    m_nxt     = m + 2'd1;
`endif
                    state_nxt = OV_RD;
                end
            end
            FIN: ;
            default: state_nxt = IDLE;
        endcase

        // Dropping the window abandons the scan; results freeze at their pre-edge values.
        if (in_eval && !EVAL) begin
            state_nxt   = IDLE;
            spr_cnt_nxt = spr_cnt;
            spr_ov_nxt  = spr_ov;
            spr0_ev_nxt = spr0_ev;
        end

        if (state_nxt == FIN && state != FIN) done_nxt = 1'b1;

        if (EVAL_START) begin
            state_nxt   = Y_RD;
            n_nxt       = 6'd0;
            m_nxt       = 2'd0;
            spr_cnt_nxt = 4'd0;
            spr0_ev_nxt = 1'b0;
            done_nxt    = 1'b0;
        end

        if (CLR_START) begin
            state_nxt   = CLEAR;
            clr_idx_nxt = 5'd0;
        end

        if (CLR_OV) spr_ov_nxt = 1'b0;
    end

    assign SPR_CNT = spr_cnt;
    assign SPR_OV  = spr_ov;
    assign SPR0_EV = spr0_ev;
    assign DONE    = done;

endmodule

// File: tb/tb_oam_eval_seq.sv
// Self-checking bench for oam_eval_seq: primary OAM model, write scoreboard, range-test table, abort sequences.
module tb_oam_eval_seq;

    logic       PCLK = 1'b0;
    logic       RES = 1'b1;
    logic       CLR_START = 1'b0;
    logic       EVAL_START = 1'b0;
    logic       EVAL = 1'b0;
    logic       CLR_OV = 1'b0;
    logic [7:0] V_LINE = 8'd0;
    logic       OBJ_H16 = 1'b0;
    logic [7:0] OAM_DI = 8'h00;
    logic [7:0] OAM_A;
    logic [4:0] OAM2_A;
    logic [7:0] OAM2_DO;
    logic       OAM2_WE;
    logic [3:0] SPR_CNT;
    logic       SPR_OV;
    logic       SPR0_EV;
    logic       DONE;

    always #5 PCLK = ~PCLK;

    oam_eval_seq dut (
        .PCLK(PCLK), .RES(RES), .CLR_START(CLR_START), .EVAL_START(EVAL_START),
        .EVAL(EVAL), .CLR_OV(CLR_OV), .V_LINE(V_LINE), .OBJ_H16(OBJ_H16),
        .OAM_DI(OAM_DI), .OAM_A(OAM_A), .OAM2_A(OAM2_A), .OAM2_DO(OAM2_DO),
        .OAM2_WE(OAM2_WE), .SPR_CNT(SPR_CNT), .SPR_OV(SPR_OV), .SPR0_EV(SPR0_EV),
        .DONE(DONE)
    );

    // Primary OAM with one-cycle read latency, secondary OAM capturing writes.
    logic [7:0] prim [0:255];
    logic [7:0] sec  [0:31];
    always @(posedge PCLK) OAM_DI <= prim[OAM_A];
    always @(posedge PCLK) if (OAM2_WE === 1'b1) sec[OAM2_A] <= OAM2_DO;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    bit  mon_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (mon_en && OAM2_WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL oam2_unexpected_write: got addr %0d data %0h, required no write", OAM2_A, OAM2_DO);
            end else begin
                mon_e = exp_q.pop_front();
                check("oam2_addr", {27'd0, OAM2_A}, {27'd0, mon_e.a});
                check("oam2_data", {24'd0, OAM2_DO}, {24'd0, mon_e.d});
            end
        end
    end

    function automatic bit hit(input logic [7:0] vl, input logic [7:0] y, input logic h16);
        int d;
        d = int'(vl) - int'(y);
        return (d >= 0) && (d < (h16 ? 16 : 8));
    endfunction

    // Reference scan: pushes the expected secondary writes and returns the cycle count.
    task automatic model(input logic [7:0] vl, input logic h16, output int cyc);
        int cnt;
        int n;
        int m;
        cnt = 0;
        n   = 0;
        cyc = 0;
        while (n < 64 && cnt < 8) begin
            exp_q.push_back('{a: 5'(cnt * 4), d: prim[n * 4]});
            cyc += 2;
            if (hit(vl, prim[n * 4], h16)) begin
                for (int k = 1; k < 4; k++) exp_q.push_back('{a: 5'(cnt * 4 + k), d: prim[n * 4 + k]});
                cyc += 6;
                cnt++;
            end
            n++;
        end
        if (cnt == 8) begin
            m = 0;
            while (n < 64) begin
                cyc += 2;
                if (hit(vl, prim[n * 4 + m], h16)) break;
                n++;
`ifdef OAM_EVAL_OVF_BUG_EN
                m = (m + 1) % 4;
`endif
            end
        end
    endtask

    task automatic fill_all(input logic [7:0] v);
        for (int i = 0; i < 256; i++) prim[i] = v;
    endtask

    task automatic run_eval(input string tag, input logic [7:0] vl, input logic h16,
                            input int e_cnt, input bit e_spr0, input bit e_ov, output int lat);
        int cyc;
        @(negedge PCLK);
        V_LINE  = vl;
        OBJ_H16 = h16;
        EVAL    = 1'b1;
        exp_q.delete();
        model(vl, h16, cyc);
        mon_en     = 1'b1;
        EVAL_START = 1'b1;
        CLR_OV     = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        EVAL_START = 1'b0;
        CLR_OV     = 1'b0;
        lat = 1;
        while (DONE !== 1'b1 && lat < 400) begin
            @(negedge PCLK);
            lat++;
        end
        check({tag, "_done_latency"}, lat, cyc + 1);
        check({tag, "_spr_cnt"}, {28'd0, SPR_CNT}, e_cnt);
        check({tag, "_spr0_ev"}, {31'd0, SPR0_EV}, {31'd0, e_spr0});
        check({tag, "_spr_ov"}, {31'd0, SPR_OV}, {31'd0, e_ov});
        check({tag, "_writes_pending"}, exp_q.size(), 0);
        mon_en = 1'b0;
    endtask

    typedef struct {
        logic [7:0] y;
        logic [7:0] vl;
        logic       h16;
        int         cnt;
        bit         spr0;
    } vec_t;
    vec_t vt[9];

    initial begin
        int lat;
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int lat;
        vt[0] = '{8'h05, 8'd12, 1'b0, 1, 1'b1};
        vt[1] = '{8'h05, 8'd13, 1'b0, 0, 1'b0};
        vt[2] = '{8'h05, 8'd13, 1'b1, 1, 1'b1};
        vt[3] = '{8'h05, 8'h05, 1'b0, 1, 1'b1};
        vt[4] = '{8'h05, 8'h04, 1'b0, 0, 1'b0};
        vt[5] = '{8'h05, 8'h14, 1'b1, 1, 1'b1};
        vt[6] = '{8'h05, 8'h15, 1'b1, 0, 1'b0};
        vt[7] = '{8'hF0, 8'hFE, 1'b1, 1, 1'b1};
        vt[8] = '{8'hF0, 8'hFE, 1'b0, 0, 1'b0};
        fill_all(8'hFF);

        // Reset state
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_oam_a", {24'd0, OAM_A}, 0);
        check("rst_oam2_a", {27'd0, OAM2_A}, 0);
        check("rst_oam2_do", {24'd0, OAM2_DO}, 0);
        check("rst_oam2_we", {31'd0, OAM2_WE}, 0);
        check("rst_spr_cnt", {28'd0, SPR_CNT}, 0);
        check("rst_spr_ov", {31'd0, SPR_OV}, 0);
        check("rst_spr0_ev", {31'd0, SPR0_EV}, 0);
        check("rst_done", {31'd0, DONE}, 0);
        RES = 1'b0;

        // Secondary OAM clear
        @(negedge PCLK);
        CLR_START = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        CLR_START = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("clr_we", {31'd0, OAM2_WE}, 1);
            check("clr_do", {24'd0, OAM2_DO}, 32'hFF);
            check("clr_addr", {27'd0, OAM2_A}, i);
            @(negedge PCLK);
        end
        check("clr_we_after", {31'd0, OAM2_WE}, 0);

        // All entries out of range
        fill_all(8'hFF);
        run_eval("all_miss", 8'd10, 1'b0, 0, 1'b0, 1'b0, lat);
        check("all_miss_latency_129", lat, 129);

        // Range test table on entry 0
        for (int r = 0; r < 9; r++) begin
            fill_all(8'hFF);
            prim[0] = vt[r].y;
            prim[1] = 8'h12;
            prim[2] = 8'h34;
            prim[3] = 8'h56;
            run_eval($sformatf("vec%0d", r), vt[r].vl, vt[r].h16, vt[r].cnt, vt[r].spr0, 1'b0, lat);
            if (r == 0) begin
                @(negedge PCLK);
                check("vec0_sec0", {24'd0, sec[0]}, 32'h05);
                check("vec0_sec1", {24'd0, sec[1]}, 32'h12);
                check("vec0_sec2", {24'd0, sec[2]}, 32'h34);
                check("vec0_sec3", {24'd0, sec[3]}, 32'h56);
            end
        end

        // Nine hits: eight copied, ninth sets overflow
        fill_all(8'hFF);
        for (int e = 0; e < 9; e++) begin
            prim[e * 4]     = 8'd20;
            prim[e * 4 + 1] = 8'(e);
            prim[e * 4 + 2] = 8'(8'h40 + e);
            prim[e * 4 + 3] = 8'(8'h80 + e);
        end
        run_eval("ovf9", 8'd22, 1'b0, 8, 1'b1, 1'b1, lat);
        repeat (3) @(negedge PCLK);
        check("ovf_sticky", {31'd0, SPR_OV}, 1);
        CLR_OV = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        CLR_OV = 1'b0;
        check("ovf_cleared", {31'd0, SPR_OV}, 0);

        // Diagonal overflow scan: entry 9 byte 1 only matters with the bug enabled
        fill_all(8'hFF);
        for (int e = 0; e < 8; e++) begin
            prim[e * 4]     = 8'd20;
            prim[e * 4 + 1] = 8'(8'h10 + e);
        end
        prim[37] = 8'h16;
`ifdef OAM_EVAL_OVF_BUG_EN
        run_eval("diag", 8'd22, 1'b0, 8, 1'b1, 1'b1, lat);
`else
        run_eval("diag", 8'd22, 1'b0, 8, 1'b1, 1'b0, lat);
`endif

        // Reset in the middle of a copy
        fill_all(8'hFF);
        prim[0] = 8'd20; prim[1] = 8'h01; prim[2] = 8'h02; prim[3] = 8'h03;
        @(negedge PCLK);
        V_LINE = 8'd22; OBJ_H16 = 1'b0; EVAL = 1'b1; EVAL_START = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        EVAL_START = 1'b0;
        repeat (4) @(negedge PCLK);
        check("res_pre_spr0", {31'd0, SPR0_EV}, 1);
        RES = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        RES = 1'b0;
        check("res_we", {31'd0, OAM2_WE}, 0);
        check("res_oam_a", {24'd0, OAM_A}, 0);
        check("res_spr_cnt", {28'd0, SPR_CNT}, 0);
        check("res_spr0", {31'd0, SPR0_EV}, 0);
        check("res_done", {31'd0, DONE}, 0);
        repeat (3) @(negedge PCLK);
        check("res_idle_we", {31'd0, OAM2_WE}, 0);

        // EVAL dropped during the second copy
        fill_all(8'hFF);
        prim[0] = 8'd20;
        prim[4] = 8'd20;
        @(negedge PCLK);
        EVAL = 1'b1; EVAL_START = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        EVAL_START = 1'b0;
        repeat (10) @(negedge PCLK);
        EVAL = 1'b0;
        @(negedge PCLK);
        check("evl_we", {31'd0, OAM2_WE}, 0);
        check("evl_spr_cnt", {28'd0, SPR_CNT}, 1);
        check("evl_spr0", {31'd0, SPR0_EV}, 1);
        check("evl_done", {31'd0, DONE}, 0);
        repeat (5) @(negedge PCLK);
        check("evl_hold_cnt", {28'd0, SPR_CNT}, 1);
        check("evl_hold_we", {31'd0, OAM2_WE}, 0);
        check("evl_hold_done", {31'd0, DONE}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
